// File: rtl/rr3_arbiter_pkg.sv
// rr3_arbiter_pkg
//   Shared definitions for the three-requester round-robin arbiter:
//   FSM state encoding, mod-3 pointer constants, requester count and
//   the combinational search / pointer-advance helpers.
package rr3_arbiter_pkg;

  localparam int unsigned N_REQ = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;

  // First set request searching ptr, ptr+1, ptr+2 (mod 3); returns a
  // one-hot grant or zero. The illegal pointer 2'b11 falls into the
  // default arm and therefore searches like P0.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [1:0]       p);
    logic [N_REQ-1:0] g;
    g = '0;
    case (p)
      P1: begin
        if      (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
      end
      P2: begin
        if      (r[2]) g = 3'b100;
        else if (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
      end
      default: begin
        if      (r[0]) g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  // Pointer value after granting requester k: (k+1) mod 3.
  function automatic logic [1:0] ptr_after(input logic [N_REQ-1:0] g);
    logic [1:0] p;
    case (g)
      3'b010:  p = P2;
      3'b100:  p = P0;
      default: p = P1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rr3_arbiter_ptr.sv
// rr3_ptr
//   Registered mod-3 priority pointer.
//   i_clk      : clock, rising edge
//   i_reset_n  : synchronous active-low reset (pointer -> 0)
//   i_load     : load i_load_val this edge
//   i_load_val : next pointer value (0..2)
//   o_value    : registered pointer
//   An illegal value 2'b11 is forced back to 0 on the next edge when
//   no load is pending.
module rr3_ptr
  import rr3_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [1:0] i_load_val,
  output logic [1:0] o_value
);

  logic [1:0] r_val;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_val <= P0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (r_val == 2'b11) begin
      r_val <= P0;
    end
  end

  assign o_value = r_val;

endmodule

// File: rtl/rr3_arbiter.sv
// rr3_arbiter
//   Three-requester round-robin arbiter with registered one-hot grant.
//   Parameter HOLD_MAX (1..255): maximum grant hold in cycles, only
//   used when the macro RR3_TIMEOUT_EN is defined.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   req     : level-sensitive requests, bit k = requester k
//   done    : release strobe from the current holder
//   gnt     : registered grant, one-hot or zero
//   busy    : |gnt
//   ptr     : registered mod-3 priority pointer
//   timeout : one-cycle pulse when a grant is revoked by the hold limit
//   Build option: define RR3_TIMEOUT_EN to add the 8-bit hold counter;
//   otherwise grants are held until done and timeout is tied low.
module rr3_arbiter
  import rr3_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [1:0]       ptr,
  output logic             timeout
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr3_arbiter: HOLD_MAX must be in 1..255");
  end

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_pick;
  logic [1:0]       w_ptr;
  logic             w_arb;
  logic             w_load;
  logic             w_expire;

  // Arbitrate in IDLE, on release, or on hold-limit expiry; release and
  // expiry both re-search from the pointer updated at the last grant.
  assign w_pick = rr_pick(req, w_ptr);
  assign w_arb  = (r_state == IDLE) || done || w_expire;
  assign w_load = w_arb && (|w_pick);

  rr3_ptr u_ptr (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_load     (w_load),
    .i_load_val (ptr_after(w_pick)),
    .o_value    (w_ptr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
    end else if (w_arb) begin
      if (|w_pick) begin
        r_state <= GRANT;
        r_gnt   <= w_pick;
      end else begin
        r_state <= IDLE;
        r_gnt   <= '0;
      end
    end
  end

`ifdef RR3_TIMEOUT_EN
  localparam logic [7:0] L_HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold;
  logic       r_timeout;

  // done in the expiry cycle wins: it is a normal release, no pulse.
  assign w_expire = (r_state == GRANT) && !done && (r_hold == L_HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_arb) begin
        r_hold <= '0;
      end else begin
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign gnt  = r_gnt;
  assign busy = |r_gnt;
  assign ptr  = w_ptr;

endmodule

// File: tb/tb_rr3_arbiter.sv
module tb_rr3_arbiter;
  import rr3_arbiter_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic       busy;
  logic [1:0] ptr;
  logic       timeout;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] ptr;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drive_done = 0;

  rr3_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .ptr     (ptr),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one input vector (optionally repeated) at the falling edge and
  // queue the outputs expected just after the following rising edge.
  task automatic vec(input logic rst, input logic [2:0] r, input logic d,
                     input logic frc, input logic [2:0] eg,
                     input logic [1:0] ep, input logic eto,
                     input int unsigned rep);
    exp_t e;
    for (int unsigned n = 0; n < rep; n++) begin
      @(negedge clk);
      if (frc) begin
        force dut.u_ptr.r_val = 2'b11;
        #1;
        release dut.u_ptr.r_val;
      end
      reset_n = rst;
      req     = r;
      done    = d;
      e.gnt   = eg;
      e.ptr   = ep;
      e.to    = eto;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt) begin
          errors++;
          $display("FAIL gnt: got %b expected %b at %0t", gnt, e.gnt, $time);
        end
        checks++;
        if (busy !== (|e.gnt)) begin
          errors++;
          $display("FAIL busy: got %b expected %b at %0t", busy, |e.gnt, $time);
        end
        checks++;
        if (ptr !== e.ptr) begin
          errors++;
          $display("FAIL ptr: got %0d expected %0d at %0t", ptr, e.ptr, $time);
        end
        checks++;
        if (timeout !== e.to) begin
          errors++;
          $display("FAIL timeout: got %b expected %b at %0t", timeout, e.to, $time);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = 3'b000;
    done    = 1'b0;

`ifdef RR3_TIMEOUT_EN
    //  rst  req     done frc  gnt     ptr  to   rep
    vec(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 2);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 1);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 3);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b100, 2'd0, 1'b1, 1);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b100, 2'd0, 1'b0, 3);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 2'd1, 1'b1, 1);
    vec(1'b1, 3'b101, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 3);
    // done in the would-be expiry cycle: normal release, no pulse
    vec(1'b1, 3'b101, 1'b1, 1'b0, 3'b100, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1);
    // reset during a grant: drop with no pulse
    vec(1'b1, 3'b010, 1'b0, 1'b0, 3'b010, 2'd2, 1'b0, 1);
    vec(1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1);
`else
    //  rst  req     done frc  gnt     ptr  to   rep
    // reset, then 111 with done every 3rd cycle
    vec(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1);
    vec(1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b111, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 2);
    vec(1'b1, 3'b111, 1'b1, 1'b0, 3'b010, 2'd2, 1'b0, 1);
    vec(1'b1, 3'b111, 1'b0, 1'b0, 3'b010, 2'd2, 1'b0, 2);
    vec(1'b1, 3'b111, 1'b1, 1'b0, 3'b100, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b111, 1'b0, 1'b0, 3'b100, 2'd0, 1'b0, 2);
    vec(1'b1, 3'b111, 1'b1, 1'b0, 3'b001, 2'd1, 1'b0, 1);
    // holder alone re-wins; with competition it loses
    vec(1'b1, 3'b001, 1'b1, 1'b0, 3'b001, 2'd1, 1'b0, 1);
    vec(1'b1, 3'b011, 1'b1, 1'b0, 3'b010, 2'd2, 1'b0, 1);
    // grant held with req dropped, then released with no requests
    vec(1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 2'd2, 1'b0, 10);
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd2, 1'b0, 1);
    // done in IDLE ignored
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd2, 1'b0, 1);
    // ptr=2 in IDLE, req=011 -> requester 0
    vec(1'b1, 3'b011, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b0, 1'b0, 3'b001, 2'd1, 1'b0, 1);
    // reset during grant
    vec(1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b010, 1'b0, 1'b0, 3'b010, 2'd2, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd2, 1'b0, 1);
    // illegal ptr 2'b11 searches like 0 and recovers to 0
    vec(1'b1, 3'b100, 1'b0, 1'b1, 3'b100, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 2'd0, 1'b0, 1);
    vec(1'b1, 3'b011, 1'b0, 1'b1, 3'b001, 2'd1, 1'b0, 1);
    vec(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'd1, 1'b0, 1);
`endif

    drive_done = 1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
